// File: rtl/ok_host_stream_bridge_pkg.sv
// Shared constants for the host stream bridge: default lane geometry,
// status-bit positions and the FIFO pointer type.
package ok_bridge_pkg;

    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TX_LANES    = 2;
    localparam int DEF_RX_LANES    = 1;
    localparam int DEF_DEPTH       = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TX_W        = DEF_TX_LANES * DEF_DATA_W;
    localparam int DEF_RX_W        = DEF_RX_LANES * DEF_DATA_W;
    localparam int DEF_PTR_W       = $clog2(DEF_DEPTH) + 1;

    localparam int STAT_TX_OVF = 0;
    localparam int STAT_RX_UNF = 1;

    typedef logic [DEF_PTR_W-1:0] ptr_t;

endpackage

// File: rtl/ok_host_stream_bridge_if.sv
// Bundle of host-wire and emulator-handshake signals around the bridge.
// The bridge itself uses the slave view; whoever drives host and emulator uses master.
interface ok_host_stream_bridge_if
    import ok_bridge_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TX_LANES = DEF_TX_LANES,
    parameter int RX_LANES = DEF_RX_LANES,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CNT_W    = DEF_CNT_W
);
    localparam int TX_W    = TX_LANES * DATA_W;
    localparam int RX_W    = RX_LANES * DATA_W;
    localparam int SPACE_W = $clog2(DEPTH) + 1;

    logic               host_tx_tog;
    logic [TX_W-1:0]    host_tx_bits;
    logic [CNT_W-1:0]   host_tx_count;
    logic [SPACE_W-1:0] host_tx_space;
    logic               emu_tx_valid;
    logic               emu_tx_ready;
    logic [TX_W-1:0]    emu_tx_bits;
    logic               emu_rx_valid;
    logic               emu_rx_ready;
    logic [RX_W-1:0]    emu_rx_bits;
    logic               host_rx_valid;
    logic [RX_W-1:0]    host_rx_bits;
    logic               host_rx_tog;
    logic [CNT_W-1:0]   host_rx_count;
    logic [1:0]         host_status;

    modport slave (
        input  host_tx_tog, host_tx_bits, emu_tx_ready, emu_rx_valid, emu_rx_bits, host_rx_tog,
        output host_tx_count, host_tx_space, emu_tx_valid, emu_tx_bits, emu_rx_ready,
               host_rx_valid, host_rx_bits, host_rx_count, host_status
    );

    modport master (
        output host_tx_tog, host_tx_bits, emu_tx_ready, emu_rx_valid, emu_rx_bits, host_rx_tog,
        input  host_tx_count, host_tx_space, emu_tx_valid, emu_tx_bits, emu_rx_ready,
               host_rx_valid, host_rx_bits, host_rx_count, host_status
    );

endinterface

// File: rtl/ok_host_stream_bridge_fifo.sv
// First-word-fall-through synchronous FIFO; the head reads as zero while empty
// so nothing stale is ever visible after a reset.
module ok_stream_fifo
    import ok_bridge_pkg::*;
#(
    parameter int W     = DEF_TX_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push_i,
    input  logic [W-1:0]             data_i,
    input  logic                     pop_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic             doPush, doPop;

    // Extra pointer MSB distinguishes full (MSBs differ) from empty (equal).
    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign count_o = wrPtr_q - rdPtr_q;
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

    assign doPop  = pop_i && !empty_o;
    assign doPush = push_i && (!full_o || doPop);

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        if (doPush) wrPtr_d = wrPtr_q + 1'b1;
        if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (doPush) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/ok_host_stream_bridge.sv
// Host-to-emulator stream adapter: every flip of a host toggle wire becomes exactly
// one ready/valid beat, with a FIFO in each direction and sticky error flags.
module ok_host_stream_bridge
    import ok_bridge_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TX_LANES    = DEF_TX_LANES,
    parameter int RX_LANES    = DEF_RX_LANES,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset_n,
    ok_host_stream_bridge_if.slave bus
);
    localparam int TX_W  = TX_LANES * DATA_W;
    localparam int RX_W  = RX_LANES * DATA_W;
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [SYNC_STAGES-1:0] txSync_q, rxSync_q;
    logic                   txLast_q, rxLast_q;
    logic                   active_q;
    logic [CNT_W-1:0]       txCount_q, txCount_d;
    logic [CNT_W-1:0]       rxCount_q, rxCount_d;
    logic                   txOvf_q, txOvf_d;
    logic                   rxUnf_q, rxUnf_d;

    logic                   txEdge, rxEdge;
    logic                   txPush, txPop, txFull, txEmpty;
    logic [PTR_W-1:0]       txLevel;
    logic [TX_W-1:0]        txHead;
    logic                   rxPush, rxPop, rxFull, rxEmpty, rxReady;
    logic [PTR_W-1:0]       rxLevel;
    logic [RX_W-1:0]        rxHead;

    // active_q holds space/ready at zero while in reset so every output reads 0 then.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            txSync_q  <= '0;
            rxSync_q  <= '0;
            txLast_q  <= 1'b0;
            rxLast_q  <= 1'b0;
            active_q  <= 1'b0;
            txCount_q <= '0;
            rxCount_q <= '0;
            txOvf_q   <= 1'b0;
            rxUnf_q   <= 1'b0;
        end else begin
            txSync_q  <= {txSync_q[SYNC_STAGES-2:0], bus.host_tx_tog};
            rxSync_q  <= {rxSync_q[SYNC_STAGES-2:0], bus.host_rx_tog};
            txLast_q  <= txSync_q[SYNC_STAGES-1];
            rxLast_q  <= rxSync_q[SYNC_STAGES-1];
            active_q  <= 1'b1;
            txCount_q <= txCount_d;
            rxCount_q <= rxCount_d;
            txOvf_q   <= txOvf_d;
            rxUnf_q   <= rxUnf_d;
        end
    end

    // Both toggle polarities count as one event each.
    assign txEdge = txSync_q[SYNC_STAGES-1] ^ txLast_q;
    assign rxEdge = rxSync_q[SYNC_STAGES-1] ^ rxLast_q;

    // A full TX FIFO still takes the word when the emulator frees the head this cycle.
    assign txPop   = !txEmpty && bus.emu_tx_ready;
    assign txPush  = txEdge && (!txFull || txPop);
    assign rxReady = active_q && !rxFull;
    assign rxPush  = bus.emu_rx_valid && rxReady;
    assign rxPop   = rxEdge && !rxEmpty;

    always_comb begin
        txCount_d = txCount_q + CNT_W'(txPush);
        rxCount_d = rxCount_q + CNT_W'(rxPop);
        txOvf_d   = txOvf_q | (txEdge & ~txPush);
        rxUnf_d   = rxUnf_q | (rxEdge & rxEmpty);
    end

    ok_stream_fifo #(.W(TX_W), .DEPTH(DEPTH)) txFifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (txPush),
        .data_i  (bus.host_tx_bits),
        .pop_i   (txPop),
        .data_o  (txHead),
        .full_o  (txFull),
        .empty_o (txEmpty),
        .count_o (txLevel)
    );

    ok_stream_fifo #(.W(RX_W), .DEPTH(DEPTH)) rxFifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push_i  (rxPush),
        .data_i  (bus.emu_rx_bits),
        .pop_i   (rxPop),
        .data_o  (rxHead),
        .full_o  (rxFull),
        .empty_o (rxEmpty),
        .count_o (rxLevel)
    );

    assign bus.emu_tx_valid  = !txEmpty;
    assign bus.emu_tx_bits   = txHead;
    assign bus.emu_rx_ready  = rxReady;
    assign bus.host_rx_valid = (rxLevel != '0);
    assign bus.host_rx_bits  = rxHead;
    assign bus.host_tx_count = txCount_q;
    assign bus.host_rx_count = rxCount_q;
    assign bus.host_tx_space = active_q ? (PTR_W'(DEPTH) - txLevel) : '0;
    assign bus.host_status[STAT_TX_OVF] = txOvf_q;
    assign bus.host_status[STAT_RX_UNF] = rxUnf_q;

endmodule
